// File: rtl/lfsr_ctrl_if.sv
// Board-side bundle between the LFSR sequencer, the buttons/switches, the LFSR register and the LEDs.
// The master drives the strobes, seed and status; the slave supplies the buttons, switches and LFSR value.
interface lfsr_ctrl_if;
  logic [4:0]  btn;
  logic [7:0]  sw;
  logic [7:0]  lfsr_q;
  logic        lfsr_step;
  logic        lfsr_load;
  logic [7:0]  lfsr_seed;
  logic [15:0] ledr;

  modport master (
    input  btn, sw, lfsr_q,
    output lfsr_step, lfsr_load, lfsr_seed, ledr
  );

  modport slave (
    output btn, sw, lfsr_q,
    input  lfsr_step, lfsr_load, lfsr_seed, ledr
  );
endinterface

// File: rtl/lfsr_ctrl.sv
// Button-driven sequencer for an external 8-bit LFSR: debounced step/load/run/speed/display, lockup recovery, period measurement.
// Latency: step/load strobe one cycle after the debounced press (DEB_CYCLES+2 after first high sample); no backpressure, losing presses are dropped.
module lfsr_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_BASE  = 8,
  parameter int CNT_W      = 9
) (
  input  logic       clk,
  input  logic       rst,
  lfsr_ctrl_if.master bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int PW = $clog2(TICK_BASE << 3);

  typedef enum logic [1:0] {IDLE, RUN, LOAD} state_t;

  logic [4:0]    sync1, sync2, acc, press;
  logic [DW-1:0] deb_cnt [5];

  state_t        state, state_nxt;
  logic          ret_run, ret_run_nxt;
  logic          cur_run;
  logic          step_r, step_nxt;
  logic [7:0]    seed_r, seed_nxt;
  logic          lock, lock_nxt;
  logic          user_load, presc_clr;
  logic          lock_rec, tick;
  logic [1:0]    speed;
  logic          disp_sel;
  logic [PW-1:0] presc, presc_term;
  logic [CNT_W-1:0] step_cnt, period;
  logic          sat, chk, period_valid;

  // Debouncers: a level is accepted after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      press <= '0;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= bus.btn;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          acc[i]     <= sync2[i];
          press[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign cur_run    = (state == RUN) || (state == LOAD && ret_run);
  assign lock_rec   = (bus.lfsr_q == 8'h00) && (state != LOAD);
  assign presc_term = PW'((TICK_BASE << speed) - 1);
  assign tick       = (state == RUN) && (presc == presc_term);
  assign sat        = &step_cnt;

  always_comb begin
    state_nxt   = state;
    ret_run_nxt = ret_run;
    step_nxt    = 1'b0;
    seed_nxt    = seed_r;
    lock_nxt    = lock;
    user_load   = 1'b0;
    presc_clr   = 1'b0;
    if (lock_rec) begin
      state_nxt   = LOAD;
      ret_run_nxt = cur_run;
      seed_nxt    = 8'h01;
      lock_nxt    = 1'b1;
    end else if (press[1]) begin
      state_nxt   = LOAD;
      ret_run_nxt = cur_run;
      seed_nxt    = (bus.sw == 8'h00) ? 8'h01 : bus.sw;
      lock_nxt    = 1'b0;
      user_load   = 1'b1;
      presc_clr   = 1'b1;
    end else if (press[2]) begin
      // A toggle during LOAD redirects where LOAD returns to.
      state_nxt   = cur_run ? IDLE : RUN;
      ret_run_nxt = !cur_run;
      presc_clr   = 1'b1;
    end else begin
      case (state)
        IDLE:    step_nxt  = press[0];
        RUN:     step_nxt  = tick;
        LOAD:    state_nxt = ret_run ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (presc_clr || press[3]) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ret_run      <= 1'b0;
      step_r       <= 1'b0;
      seed_r       <= 8'h01;
      lock         <= 1'b0;
      speed        <= 2'd0;
      disp_sel     <= 1'b0;
      step_cnt     <= '0;
      chk          <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      ret_run <= ret_run_nxt;
      step_r  <= step_nxt;
      seed_r  <= seed_nxt;
      lock    <= lock_nxt;
      chk     <= step_r;
      if (press[3]) speed <= speed + 2'd1;
      if (press[4]) disp_sel <= !disp_sel;
      if (user_load) begin
        step_cnt     <= '0;
        period_valid <= 1'b0;
      end else begin
        if (step_r && !sat) step_cnt <= step_cnt + 1'b1;
        // chk lines up with the LFSR value produced by the previous step.
        if (chk && !period_valid && !sat && bus.lfsr_q == seed_r) begin
          period       <= step_cnt;
          period_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.lfsr_step = step_r;
  assign bus.lfsr_load = (state == LOAD);
  assign bus.lfsr_seed = seed_r;
  assign bus.ledr      = {disp_sel, 1'b0, period[CNT_W-1], period_valid, lock, speed, cur_run,
                          disp_sel ? period[7:0] : bus.lfsr_q};

endmodule

// File: doc/lfsr_ctrl.md
Name: lfsr_ctrl

Overview:
Board-level sequencer for the 8-bit LED LFSR datapath on the nvboard example. It turns raw buttons into debounced one-shot commands: single step, seed load from switches, free-run at a selectable rate, and display select. It drives step/load strobes to an external LFSR register and recovers automatically from the all-zero lockup state. It measures the sequence period after each load and presents state and results on ledr.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change
TICK_BASE, 8, base run-mode step period in clk cycles; effective period = TICK_BASE << speed
CNT_W, 9, width of the step/period counter (saturating)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (0 = reset)
btn  in  5  raw buttons: [0] step, [1] load seed, [2] run/stop toggle, [3] speed cycle, [4] display toggle
sw  in  8  seed value for load
lfsr_q  in  8  current LFSR register value; updates the cycle after a step or load strobe
lfsr_step  out  1  one-cycle advance strobe to the LFSR
lfsr_load  out  1  one-cycle load strobe; LFSR takes lfsr_seed
lfsr_seed  out  8  value to load
ledr  out  16  status display

Behaviour:
- Reset (rst=0, async): state IDLE, lfsr_step=0, lfsr_load=0, lfsr_seed=8'h01, speed=0, disp_sel=0, lock=0, period_valid=0, step_cnt=0, prescaler=0, all debouncers released.
- Debounce, per button: 2-FF synchronizer, then a stable counter. Once the synced level has differed from the accepted level for DEB_CYCLES consecutive cycles, the new level is accepted. A press pulse is asserted for exactly 1 cycle on the accepted 0->1 transition. For a clean press, the pulse occurs DEB_CYCLES+2 cycles after the first high sample. Any glitch shorter than DEB_CYCLES produces no pulse. Holding a button gives exactly one pulse.
- FSM states:
  - IDLE: halted.
  - RUN: auto-stepping.
  - LOAD: 1 cycle, asserts lfsr_load, then returns to the saved state (IDLE or RUN).
- Priority per cycle, highest first:
  1. Lockup recovery.
  2. Load press.
  3. Run toggle.
  4. Step press / run tick.
  A lower-priority press that loses arbitration is dropped, not queued.
- Lockup recovery: if lfsr_q==0 and the FSM is not in LOAD, enter LOAD with lfsr_seed=8'h01 and set sticky lock=1. Only reset or a user load clears lock.
- Load press: lfsr_seed <= (sw==0) ? 8'h01 : sw. Enter LOAD next cycle, so lfsr_load is high 1 cycle after the press pulse. Also clears step_cnt, period_valid and lock, and resets the prescaler.
- IDLE: a step press pulse makes lfsr_step=1 on the next cycle, for 1 cycle. Run press -> RUN.
- RUN:
  - The prescaler counts 0..(TICK_BASE<<speed)-1; at terminal count lfsr_step=1 for 1 cycle and the counter wraps to 0.
  - Step presses are ignored.
  - Run press -> IDLE and clears the prescaler.
- Speed press: speed <= speed+1 mod 4. The prescaler is cleared on change.
- Display press: disp_sel toggles.
- Period measurement:
  - step_cnt increments (saturating at 2^CNT_W-1) on each lfsr_step.
  - A delayed flag chk = lfsr_step registered. When chk && !period_valid && lfsr_q==lfsr_seed: period <= step_cnt, period_valid <= 1.
  - If step_cnt saturates first, period_valid stays 0.
- ledr:
  - [7:0] = disp_sel ? period[7:0] : lfsr_q (combinational from lfsr_q).
  - [8] = run.
  - [10:9] = speed.
  - [11] = lock.
  - [12] = period_valid.
  - [13] = period[8].
  - [14] = 0.
  - [15] = disp_sel.
- Reset mid-operation: immediate return to reset values. Pending strobes are cancelled and never emitted.

Test Plan:
- Bench LFSR stub = rotate-right (period 8 for seed 01); lfsr_q=0 after bench reset. Release rst -> lfsr_load pulse with lfsr_seed=01; ledr[11]=1; lfsr_q becomes 01.
- sw=8'h00, press btn[1] -> lfsr_seed=01, lfsr_load 1 cycle; lock cleared. Then sw=8'h81, press btn[1] -> lfsr_seed=81, step_cnt=0.
- IDLE, press btn[0] 3 times -> exactly 3 lfsr_step pulses, each DEB_CYCLES+3 cycles after its press starts. A 2-cycle glitch on btn[0] -> no pulse.
- Press btn[2] with speed=0 -> lfsr_step every 8 cycles. Press btn[3] twice -> every 32 cycles, ledr[10:9]=2'b10. Press btn[2] again -> stepping stops, ledr[8]=0.
- Load seed 01, run -> after 8 steps period=8, ledr[12]=1. Press btn[4] -> ledr[7:0]=8'h08, ledr[15]=1.
- Load press and run tick in the same cycle -> lfsr_load only, no step that cycle. rst asserted while in LOAD -> no lfsr_load, all outputs at reset values.
